// File: rtl/pc_fetch_if.sv
// SRAM-like instruction bus between the fetch stage (master) and instruction memory (slave).
// One request is outstanding at a time: the address phase ends with inst_addr_ok, the data phase with inst_data_ok.
interface pc_fetch_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   modport master (
      output inst_req, inst_addr,
      input  inst_addr_ok, inst_data_ok, inst_rdata
   );

   modport slave (
      input  inst_req, inst_addr,
      output inst_addr_ok, inst_data_ok, inst_rdata
   );
endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one instruction per request, handles flush/branch redirects.
// Optional fetch-address-error detection is enabled by defining IF_ADEL_CHECK_EN.
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic              flush,
   input  logic [31:0]       new_pc,
   input  logic              branch_flag_i,
   input  logic [31:0]       branch_target_address_i,
   pc_fetch_if.master        bus,
   output logic [31:0]       if_pc,
   output logic [31:0]       if_inst,
   output logic              if_adel,
   output logic              stallreq_if
);

   typedef enum logic [2:0] {BOOT, REQ, WAIT, DISCARD, DONE} state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic [31:0] pend_pc;
   logic        pend_valid;
   logic        misaligned;
   logic        accepted;
   logic        branch_take;
   logic        done_advance;
   logic        unused_stall;

`ifdef IF_ADEL_CHECK_EN
   assign misaligned = (pc[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   assign bus.inst_req   = (state == REQ) && !misaligned;
   assign bus.inst_addr  = pc;
   assign accepted       = bus.inst_req && bus.inst_addr_ok;
   assign branch_take    = branch_flag_i && !stall[2];
   assign done_advance   = (state == DONE) && !flush && !stall[0];
   assign unused_stall   = ^{stall[5:3], stall[1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   // flush outranks every transition; a flush that coincides with an accepted address must still swallow its data
   always_comb begin
      state_next  = state;
      stallreq_if = 1'b1;
      case (state)
         BOOT: state_next = REQ;
         REQ: begin
            if (flush) begin
               state_next = accepted ? DISCARD : REQ;
            end else if (misaligned) begin
               state_next = DONE;
            end else if (accepted) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (flush) begin
               state_next = bus.inst_data_ok ? REQ : DISCARD;
            end else if (bus.inst_data_ok) begin
               state_next = DONE;
            end
         end
         DISCARD: begin
            if (bus.inst_data_ok) begin
               state_next = REQ;
            end
         end
         DONE: begin
            stallreq_if = 1'b0;
            if (flush || !stall[0]) begin
               state_next = REQ;
            end
         end
         default: state_next = BOOT;
      endcase
   end

   always_comb begin
      pc_next = pc + 32'd4;
      if (branch_take) begin
         pc_next = branch_target_address_i;
      end else if (pend_valid) begin
         pc_next = pend_pc;
      end
   end

   // A taken branch seen outside DONE-advance is remembered so it applies after the delay slot is fetched
   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_PC;
         pend_valid <= 1'b0;
         pend_pc    <= 32'h0;
         if_pc      <= 32'h0;
         if_inst    <= 32'h0;
      end else if (flush) begin
         pc         <= new_pc;
         pend_valid <= 1'b0;
         if (state == DONE) begin
            if_pc   <= 32'h0;
            if_inst <= 32'h0;
         end
      end else begin
         if (done_advance) begin
            pc         <= pc_next;
            pend_valid <= 1'b0;
         end else if (branch_take) begin
            pend_valid <= 1'b1;
            pend_pc    <= branch_target_address_i;
         end
         if ((state == WAIT) && bus.inst_data_ok) begin
            if_pc   <= pc;
            if_inst <= bus.inst_rdata;
         end else if ((state == REQ) && misaligned) begin
            if_pc   <= pc;
            if_inst <= 32'h0;
         end
      end
   end

`ifdef IF_ADEL_CHECK_EN
   logic adel_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         adel_q <= 1'b0;
      end else if ((state == REQ) && !flush && misaligned) begin
         adel_q <= 1'b1;
      end else if ((state == DONE) && (state_next != DONE)) begin
         adel_q <= 1'b0;
      end
   end

   assign if_adel = adel_q;
`else
   assign if_adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: a responsive bus model, a scoreboard of expected fetches,
// a vector table for plain sequential fetches and hand-written redirect/flush/reset sequences.
module tb_pc_fetch;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } exp_t;

   typedef struct {
      int          addr_wait;
      int          data_delay;
      int          stall_cycles;
      logic [31:0] exp_pc;
      logic [31:0] exp_inst;
      logic [31:0] exp_next;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        branch_flag_i;
   logic [31:0] branch_target_address_i;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_adel;
   logic        stallreq_if;

   pc_fetch_if bus ();

   pc_fetch dut (
      .clk                     (clk),
      .rst                     (rst),
      .stall                   (stall),
      .flush                   (flush),
      .new_pc                  (new_pc),
      .branch_flag_i           (branch_flag_i),
      .branch_target_address_i (branch_target_address_i),
      .bus                     (bus),
      .if_pc                   (if_pc),
      .if_inst                 (if_inst),
      .if_adel                 (if_adel),
      .stallreq_if             (stallreq_if)
   );

   int          checks = 0;
   int          errors = 0;
   int          done_count = 0;
   bit          was_done = 1'b0;
   exp_t        sb[$];

   bit          ack_enable = 1'b1;
   int          data_delay = 1;
   bit          busy = 1'b0;
   int          lat_cnt = 0;
   logic [31:0] req_addr = 32'h0;
   bit          use_override = 1'b0;
   logic [31:0] override_word = 32'h0;
   bit          drv_ack;
   bit          drv_data;
   logic [31:0] hold_pc;
   logic [31:0] hold_inst;

   vec_t        vecs[3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'hBFC00000) return 32'h24010001;
      return {~a[15:0], a[15:0]};
   endfunction

   function automatic exp_t fetch_of(input logic [31:0] a);
      exp_t e;
      e.pc   = a;
      e.inst = mem_word(a);
      e.adel = 1'b0;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [5:0] st, input logic fl, input logic [31:0] npc,
                                input logic br, input logic [31:0] tgt);
      stall                   = st;
      flush                   = fl;
      new_pc                  = npc;
      branch_flag_i           = br;
      branch_target_address_i = tgt;
   endtask

   // DONE entry is the falling edge of stallreq_if; each one must match the oldest expected fetch
   task automatic monitor();
      bit   done_now;
      exp_t e;
      done_now = (stallreq_if === 1'b0);
      if (done_now && !was_done) begin
         done_count++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_fetch actual=%h/%h expected=none", if_pc, if_inst);
         end else begin
            e = sb.pop_front();
            checkOutput("fetch_pc", if_pc, e.pc);
            checkOutput("fetch_inst", if_inst, e.inst);
            checkOutput("fetch_adel", {31'h0, if_adel}, {31'h0, e.adel});
         end
      end
      was_done = done_now;
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      drv_ack           = ack_enable && (bus.inst_req === 1'b1);
      drv_data          = busy && (lat_cnt <= 1);
      bus.inst_addr_ok  = drv_ack;
      bus.inst_data_ok  = drv_data;
      bus.inst_rdata    = drv_data ? (use_override ? override_word : mem_word(req_addr)) : 32'h0;
      if (drv_ack) req_addr = (drv_data) ? req_addr : req_addr;
      @(posedge clk);
      if (rst) begin
         busy = 1'b0;
      end else begin
         if (drv_data) busy = 1'b0;
         else if (busy) lat_cnt--;
         if (drv_ack) begin
            busy     = 1'b1;
            lat_cnt  = data_delay;
            req_addr = bus.inst_addr;
         end
      end
      #1;
   endtask

   task automatic wait_done(input int budget);
      int start;
      bit seen;
      start = done_count;
      seen  = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done_count != start) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout actual=%0d expected=%0d", done_count, start + 1);
      end
   endtask

   initial begin
      bus.inst_addr_ok = 1'b0;
      bus.inst_data_ok = 1'b0;
      bus.inst_rdata   = 32'h0;
      rst = 1'b1;
      applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);

      vecs[0] = '{0, 1, 0, 32'hBFC00004, mem_word(32'hBFC00004), 32'hBFC00008};
      vecs[1] = '{0, 3, 4, 32'hBFC00008, mem_word(32'hBFC00008), 32'hBFC0000C};
      vecs[2] = '{2, 2, 0, 32'hBFC0000C, mem_word(32'hBFC0000C), 32'hBFC00010};

      // reset values
      tick();
      tick();
      checkOutput("rst_req", {31'h0, bus.inst_req}, 32'h0);
      checkOutput("rst_addr", bus.inst_addr, 32'hBFC00000);
      checkOutput("rst_if_pc", if_pc, 32'h0);
      checkOutput("rst_if_inst", if_inst, 32'h0);
      checkOutput("rst_adel", {31'h0, if_adel}, 32'h0);
      checkOutput("rst_stallreq", {31'h0, stallreq_if}, 32'h1);

      // first fetch after reset
      rst = 1'b0;
      sb.push_back(fetch_of(32'hBFC00000));
      tick();
      checkOutput("boot_req", {31'h0, bus.inst_req}, 32'h1);
      checkOutput("boot_addr", bus.inst_addr, 32'hBFC00000);
      wait_done(20);
      checkOutput("post_boot_addr", bus.inst_addr, 32'hBFC00004);

      // sequential fetches with varied bus latency and external stall
      for (int v = 0; v < 3; v++) begin
         data_delay = vecs[v].data_delay;
         sb.push_back('{vecs[v].exp_pc, vecs[v].exp_inst, 1'b0});
         if (vecs[v].addr_wait > 0) begin
            ack_enable = 1'b0;
            for (int k = 0; k < vecs[v].addr_wait; k++) begin
               tick();
               checkOutput("req_held", {31'h0, bus.inst_req}, 32'h1);
               checkOutput("req_addr_held", bus.inst_addr, vecs[v].exp_pc);
            end
            ack_enable = 1'b1;
         end
         if (vecs[v].stall_cycles > 0) stall = 6'b000111;
         wait_done(30);
         for (int k = 1; k < vecs[v].stall_cycles; k++) begin
            tick();
            checkOutput("stall_if_pc", if_pc, vecs[v].exp_pc);
            checkOutput("stall_if_inst", if_inst, vecs[v].exp_inst);
            checkOutput("stall_no_req", {31'h0, bus.inst_req}, 32'h0);
            checkOutput("stall_in_done", {31'h0, stallreq_if}, 32'h0);
         end
         stall = 6'b0;
         if (vecs[v].stall_cycles > 0) tick();
         checkOutput("next_addr", bus.inst_addr, vecs[v].exp_next);
         checkOutput("next_req", {31'h0, bus.inst_req}, 32'h1);
      end
      data_delay = 1;

      // branch seen in REQ: delay slot fetched first, then the target
      ack_enable = 1'b0;
      applyStimulus(6'b0, 1'b0, 32'h0, 1'b1, 32'hBFC00100);
      tick();
      applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      ack_enable = 1'b1;
      sb.push_back(fetch_of(32'hBFC00010));
      sb.push_back(fetch_of(32'hBFC00100));
      wait_done(20);
      checkOutput("br_target_addr", bus.inst_addr, 32'hBFC00100);
      wait_done(20);
      checkOutput("br_after_target", bus.inst_addr, 32'hBFC00104);

      // branch while ID is held is ignored
      ack_enable = 1'b0;
      applyStimulus(6'b000100, 1'b0, 32'h0, 1'b1, 32'hBFC00200);
      tick();
      applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      ack_enable = 1'b1;
      sb.push_back(fetch_of(32'hBFC00104));
      wait_done(20);
      checkOutput("br_held_ignored", bus.inst_addr, 32'hBFC00108);

      // flush during WAIT: late data must be dropped
      data_delay = 3;
      tick();
      tick();
      applyStimulus(6'b0, 1'b1, 32'hBFC00380, 1'b0, 32'h0);
      use_override  = 1'b1;
      override_word = 32'hDEADBEEF;
      tick();
      applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("fw_addr", bus.inst_addr, 32'hBFC00380);
      checkOutput("fw_no_req", {31'h0, bus.inst_req}, 32'h0);
      checkOutput("fw_stallreq", {31'h0, stallreq_if}, 32'h1);
      tick();
      checkOutput("fw_inst_kept", if_inst, mem_word(32'hBFC00104));
      checkOutput("fw_req_again", {31'h0, bus.inst_req}, 32'h1);
      use_override = 1'b0;
      data_delay   = 1;
      sb.push_back(fetch_of(32'hBFC00380));
      wait_done(20);

      // flush in REQ without addr_ok: address switches, request stays up
      ack_enable = 1'b0;
      applyStimulus(6'b0, 1'b1, 32'hBFC00380, 1'b0, 32'h0);
      tick();
      applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("fr_req", {31'h0, bus.inst_req}, 32'h1);
      checkOutput("fr_addr", bus.inst_addr, 32'hBFC00380);
      ack_enable = 1'b1;
      sb.push_back(fetch_of(32'hBFC00380));
      wait_done(20);

      // flush in REQ coinciding with addr_ok: accepted data is discarded
      applyStimulus(6'b0, 1'b1, 32'hBFC00500, 1'b0, 32'h0);
      tick();
      applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("fa_no_req", {31'h0, bus.inst_req}, 32'h0);
      sb.push_back(fetch_of(32'hBFC00500));
      wait_done(20);
      checkOutput("fa_next_addr", bus.inst_addr, 32'hBFC00504);

      // flush in a stalled DONE clears the IF/ID outputs; then 32-bit PC wrap
      stall = 6'b000001;
      sb.push_back(fetch_of(32'hBFC00504));
      wait_done(20);
      applyStimulus(6'b000001, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0);
      tick();
      applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("fd_if_pc", if_pc, 32'h0);
      checkOutput("fd_if_inst", if_inst, 32'h0);
      checkOutput("fd_addr", bus.inst_addr, 32'hFFFFFFFC);
      checkOutput("fd_req", {31'h0, bus.inst_req}, 32'h1);
      sb.push_back(fetch_of(32'hFFFFFFFC));
      wait_done(20);
      checkOutput("wrap_addr", bus.inst_addr, 32'h00000000);

      // flush cancels a pending branch redirect
      ack_enable = 1'b0;
      applyStimulus(6'b0, 1'b0, 32'h0, 1'b1, 32'h00001000);
      tick();
      applyStimulus(6'b0, 1'b1, 32'h00002000, 1'b0, 32'h0);
      tick();
      applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      ack_enable = 1'b1;
      sb.push_back(fetch_of(32'h00002000));
      wait_done(20);
      checkOutput("pend_cleared", bus.inst_addr, 32'h00002004);

      // misaligned fetch address
      ack_enable = 1'b0;
      applyStimulus(6'b0, 1'b1, 32'hBFC00002, 1'b0, 32'h0);
      tick();
      applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      ack_enable = 1'b1;
`ifdef IF_ADEL_CHECK_EN
      checkOutput("adel_no_req", {31'h0, bus.inst_req}, 32'h0);
      sb.push_back('{32'hBFC00002, 32'h0, 1'b1});
`else
      checkOutput("mis_req", {31'h0, bus.inst_req}, 32'h1);
      checkOutput("mis_addr", bus.inst_addr, 32'hBFC00002);
      sb.push_back(fetch_of(32'hBFC00002));
`endif
      wait_done(20);
      checkOutput("mis_next_addr", bus.inst_addr, 32'hBFC00006);
      checkOutput("mis_adel_clear", {31'h0, if_adel}, 32'h0);
      applyStimulus(6'b0, 1'b1, 32'hBFC00600, 1'b0, 32'h0);
      tick();
      applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      sb.push_back(fetch_of(32'hBFC00600));
      wait_done(20);

      // reset in the middle of a fetch
      data_delay = 2;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      data_delay = 1;
      checkOutput("rm_req", {31'h0, bus.inst_req}, 32'h0);
      checkOutput("rm_addr", bus.inst_addr, 32'hBFC00000);
      checkOutput("rm_if_pc", if_pc, 32'h0);
      checkOutput("rm_if_inst", if_inst, 32'h0);
      checkOutput("rm_stallreq", {31'h0, stallreq_if}, 32'h1);
      sb.push_back(fetch_of(32'hBFC00000));
      wait_done(20);
      checkOutput("rm_next_addr", bus.inst_addr, 32'hBFC00004);

      checkOutput("sb_drained", sb.size(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch stage: owns the program counter, issues one request per instruction on the SRAM-like instruction bus, and presents the fetched `if_pc`/`if_inst` pair to the IF/ID pipeline register. It applies exception redirects (`flush`/`new_pc`) and branch redirects from ID, and accounts for the MIPS delay slot. While a fetch is outstanding it requests a pipeline stall, so IF/ID captures a bubble.

## Interface
- `RESET_PC`, 32'hBFC00000, PC value after reset.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `stall`  in  6  pipeline stall vector; bit 0 holds the PC, bit 2 means ID is held.
- `flush`  in  1  exception flush.
- `new_pc`  in  32  exception handler / ERET target; valid with `flush`.
- `branch_flag_i`  in  1  branch taken in ID.
- `branch_target_address_i`  in  32  branch target.
- `inst_req`  out  1  bus request.
- `inst_addr`  out  32  request address; equals internal `pc`.
- `inst_addr_ok`  in  1  request accepted this cycle.
- `inst_data_ok`  in  1  read data valid this cycle.
- `inst_rdata`  in  32  read data.
- `if_pc`  out  32  PC of the fetched instruction.
- `if_inst`  out  32  fetched instruction.
- `if_adel`  out  1  fetch address error; see Configuration.
- `stallreq_if`  out  1  stall request to the stall controller.

## Operation
- State machine states: BOOT, REQ, WAIT, DISCARD, DONE.
  - `inst_req`=1 only in REQ.
  - `stallreq_if`=1 in every state except DONE.
- **BOOT**: entered on `rst`; goes to REQ in the next cycle.
- **REQ**:
  - `inst_addr_ok`=1: go to WAIT.
  - `flush`=1 and `inst_addr_ok`=0: `pc`<=`new_pc`, stay in REQ. The address may change while the request is unaccepted.
  - `flush`=1 and `inst_addr_ok`=1: `pc`<=`new_pc`, go to DISCARD.
- **WAIT**:
  - `inst_data_ok`=1: `if_inst`<=`inst_rdata`, `if_pc`<=`pc`, go to DONE.
  - `flush`=1: `pc`<=`new_pc`. If `inst_data_ok` is also 1, drop the data and go to REQ; otherwise go to DISCARD.
- **DISCARD**: wait for `inst_data_ok`, drop the data, go to REQ. A `flush` in this state overwrites `pc` again.
- **DONE**: `if_pc`/`if_inst` are held.
  - `flush`=1: `pc`<=`new_pc`, `if_pc`/`if_inst`<=0, go to REQ. `stall` is ignored.
  - Else if `stall[0]`=0: `pc`<=next PC, go to REQ.
  - Else hold.
- **Next PC**, in priority order:
  1. `branch_flag_i`=1 with `stall[2]`=0: `branch_target_address_i`.
  2. Pending redirect valid: `pend_pc`; clear the pending flag.
  3. Otherwise `pc`+4, 32-bit wrap (FFFFFFFC→00000000).
- **Pending redirect**:
  - Set: any state other than DONE-advance, with `branch_flag_i`=1 and `stall[2]`=0. Records `pend_pc`<=`branch_target_address_i`, which covers the delay slot fetched after the branch.
  - Cleared by `flush` or `rst`.
- **`flush` priority**: over everything except `rst`. It clears pending redirects.

## Timing
- **Reset values**:
  - Outputs: `inst_req`=0, `inst_addr`=`RESET_PC`, `if_pc`=0, `if_inst`=0, `if_adel`=0, `stallreq_if`=1.
  - Internal: pending flag=0, state=BOOT.
- `rst` mid-fetch: abandon any outstanding data with no discard tracking. The bus side is reset by the same `rst`.
- **Minimum cycles per instruction**: 3 (REQ, WAIT, DONE), assuming `inst_addr_ok` is immediate and `inst_data_ok` arrives the following cycle.
- DONE lasts exactly one cycle unless `stall[0]`=1.
- `if_pc`/`if_inst` change only on the WAIT→DONE transition, on flush, or on reset. They are register outputs.
- `stallreq_if` is combinational from the state. It drops in the same cycle DONE is entered.

## Configuration
- **`IF_ADEL_CHECK_EN` defined**:
  - In REQ with `pc[1:0]`≠0: no request is issued.
  - Go directly to DONE with `if_inst`=0, `if_pc`=`pc`, `if_adel`=1.
  - `if_adel` clears on leaving DONE.
- **Undefined**: `if_adel` is tied to 0. Misaligned PCs are fetched as-is.

## Test plan
- **Reset**: `rst` 1 for 2 cycles; bus answers `addr_ok` immediately and `data_ok` next cycle with 0x24010001 → `inst_addr`=BFC00000, then `if_pc`=BFC00000, `if_inst`=24010001 in DONE. Next request is at BFC00004.
- **Branch with delay slot**: ID asserts `branch_flag_i`, target 0xBFC00100, for one cycle while IF is in REQ for BFC00008 → delay slot BFC00008 is fetched, then the next request is BFC00100.
- **Flush during WAIT**: `flush`, `new_pc`=0xBFC00380 → DISCARD; late `data_ok` (0xDEADBEEF) is dropped and `if_inst` is never updated. The next request is BFC00380.
- **Flush in REQ without `addr_ok`**: `inst_addr` switches to BFC00380 in the next cycle while `inst_req` stays 1.
- **External stall**: `stall`=6'b000111 held 4 cycles in DONE → state, `if_pc` and `if_inst` are stable; no request is issued.
- **With `IF_ADEL_CHECK_EN`**: flush to `new_pc`=0xBFC00002 → no `inst_req`; DONE with `if_adel`=1, `if_pc`=BFC00002, `if_inst`=0.
